// File: rtl/ysyx_22050019_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN / ILEN / RESET_VAL : default address width, instruction width, boot PC
//   INST_BYTES              : PC increment per fetched instruction
//   fetch_entry_t           : {pc, inst} pair held in the prefetch queue
package ysyx_22050019_ifu_pkg;

  localparam int unsigned     XLEN       = 64;
  localparam int unsigned     ILEN       = 32;
  localparam logic [XLEN-1:0] RESET_VAL  = 64'h0000_0000_8000_0000;
  localparam int unsigned     INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22050019_sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
//   clk, rst_n : clock, asynchronous active-high reset
//   flush      : empty the FIFO (wins over push/pop)
//   push/wdata : write one word (ignored when full without a pop)
//   pop        : drop the head word (ignored when empty)
//   rdata      : head word, meaningful only when empty==0
//   empty      : no words held
//   count      : number of words held, 0..DEPTH
module ysyx_22050019_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    rdata   = mem[rd_ptr];
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ysyx_22050019_ifu_prefetch.sv
// Fetch unit with instruction prefetch queue.
//   clk, rst_n        : clock, asynchronous active-high reset
//   redirect_i/_pc_i  : jump/branch target; flushes queue, squashes in-flight fetches
//   imem_req_o/addr_o : fetch request and address; accepted with imem_gnt_i
//   imem_rsp_*        : in-order response beats, no backpressure
//   inst_valid_o/...  : queue head {inst_addr_o, inst_o}, drained with inst_ready_i
//   idle_o            : nothing in flight and queue empty
module ysyx_22050019_ifu_prefetch #(
  parameter int unsigned     XLEN      = ysyx_22050019_ifu_pkg::XLEN,
  parameter int unsigned     ILEN      = ysyx_22050019_ifu_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_VAL = ysyx_22050019_ifu_pkg::RESET_VAL,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OSTD  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_inst_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            idle_o
);

  import ysyx_22050019_ifu_pkg::*;

  localparam int unsigned OW = $clog2(MAX_OSTD + 1);

  // Same layout as fetch_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        rsp_pc;
  logic [XLEN-1:0]        target_pc;
  logic [OW-1:0]          ostd;
  logic [OW-1:0]          drop;
  logic [OW-1:0]          ostd_nxt;
  logic                   fire_gnt;
  logic                   rsp_live;
  logic                   rsp_drop;
  logic                   credit_ok;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [$clog2(DEPTH):0] fifo_cnt;
  entry_t                 push_entry;
  entry_t                 head_entry;

  always_comb begin
    target_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
    // Live (unsquashed) requests each own a reserved FIFO slot.
    credit_ok = (32'(fifo_cnt) + 32'(ostd) - 32'(drop)) < DEPTH;
    imem_req_o = ~rst_n & ~redirect_i & (32'(ostd) < MAX_OSTD) & credit_ok;
    imem_addr_o = fetch_pc;
    fire_gnt = imem_req_o & imem_gnt_i;
    rsp_drop = imem_rsp_valid_i & (drop != '0);
    rsp_live = imem_rsp_valid_i & (drop == '0) & ~redirect_i;
    ostd_nxt = ostd + OW'(fire_gnt) - OW'(imem_rsp_valid_i);
    push_entry.pc   = rsp_pc;
    push_entry.inst = imem_rsp_inst_i;
    inst_valid_o = ~fifo_empty;
    fifo_pop     = inst_valid_o & inst_ready_i;
    inst_o       = inst_valid_o ? head_entry.inst : '0;
    inst_addr_o  = head_entry.pc;
    idle_o       = (ostd == '0) & (fifo_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fetch_pc <= RESET_VAL;
      rsp_pc   <= RESET_VAL;
      ostd     <= '0;
      drop     <= '0;
    end else begin
      ostd <= ostd_nxt;
      if (redirect_i) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        // Whatever is still in flight after this cycle belongs to the old path.
        drop     <= ostd_nxt;
      end else begin
        if (fire_gnt) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
        if (rsp_live) rsp_pc   <= rsp_pc + XLEN'(INST_BYTES);
        if (rsp_drop) drop     <= drop - OW'(1);
      end
    end
  end

  ysyx_22050019_sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_i),
    .push  (rsp_live),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  a_rsp_needs_ostd : assert property (@(posedge clk) disable iff (rst_n)
    imem_rsp_valid_i |-> (ostd != '0));

  a_ready_known : assert property (@(posedge clk) disable iff (rst_n)
    inst_valid_o |-> !$isunknown(inst_ready_i));

endmodule

// File: tb/tb_ysyx_22050019_ifu_prefetch.sv
// Directed bench for the prefetch fetch unit with a behavioural imem.
module tb_ysyx_22050019_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_inst = '0;
  logic        inst_valid;
  logic        ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        idle;

  always #5 clk = ~clk;

  ysyx_22050019_ifu_prefetch #(
    .XLEN      (64),
    .ILEN      (32),
    .RESET_VAL (64'h8000_0000),
    .DEPTH     (4),
    .MAX_OSTD  (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (gnt),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_inst_i  (rsp_inst),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (ready),
    .inst_o           (inst),
    .inst_addr_o      (inst_addr),
    .idle_o           (idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  // imem model: in-order, fixed latency, one beat per cycle
  logic [63:0] q_addr[$];
  int          q_due[$];
  int          lat    = 1;
  logic        gnt_en = 1'b1;
  int          cyc    = 0;

  logic [63:0] exp_fetch = 64'h8000_0000;
  logic [63:0] exp_pc    = 64'h8000_0000;
  int          npop      = 0;

  logic        obs_req, obs_valid, obs_idle, obs_pop, obs_rsp, obs_gnt;
  logic [63:0] obs_addr;

  task automatic step(input logic redir, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = redir;
    redirect_pc = rpc;
    ready       = rdy;
    gnt         = gnt_en;
    if (q_addr.size() != 0 && q_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_inst  = mk_inst(q_addr[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_inst  = '0;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = inst_valid;
    obs_idle  = idle;
    obs_rsp   = rsp_valid;
    obs_gnt   = imem_req & gnt;
    obs_pop   = inst_valid & rdy;
    if (obs_gnt) begin
      chk("fetch_addr", imem_addr, exp_fetch);
      exp_fetch += 64'd4;
    end
    if (obs_pop) begin
      chk("pop_pc", inst_addr, exp_pc);
      chk("pop_inst", {32'h0, inst}, {32'h0, mk_inst(exp_pc)});
      exp_pc += 64'd4;
      npop++;
    end
    if (redir) begin
      exp_fetch = rpc & ~64'h3;
      exp_pc    = rpc & ~64'h3;
    end
    @(posedge clk);
    if (obs_gnt) begin
      q_addr.push_back(obs_addr);
      q_due.push_back(cyc + lat);
    end
    if (obs_rsp) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    cyc++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    gnt       = 1'b0;
    rsp_valid = 1'b0;
    redirect  = 1'b0;
    rst_n     = 1'b0;
    exp_fetch = 64'h8000_0000;
    exp_pc    = 64'h8000_0000;
  endtask

  task automatic drain();
    bit done = 0;
    gnt_en = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      bit qe = (q_addr.size() == 0);
      step(1'b0, '0, 1'b1);
      if (qe && !obs_valid) done = 1;
    end
    chk("drain_done", {63'h0, done}, 64'd1);
    chk("drain_idle", {63'h0, obs_idle}, 64'd1);
    gnt_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n0;

    // Reset values
    #1;
    chk("rst_req",   {63'h0, imem_req},   64'd0);
    chk("rst_valid", {63'h0, inst_valid}, 64'd0);
    chk("rst_inst",  {32'h0, inst},       64'd0);
    chk("rst_idle",  {63'h0, idle},       64'd1);
    repeat (2) @(posedge clk);
    release_rst();

    // 1: zero-wait imem streaming
    lat = 1;
    n0 = npop;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1);
      if (i == 0) begin
        chk("t1_req0",  {63'h0, obs_req}, 64'd1);
        chk("t1_addr0", obs_addr, 64'h8000_0000);
      end
      chk("t1_valid", {63'h0, obs_valid}, (i >= 2) ? 64'd1 : 64'd0);
    end
    chk("t1_pops", 64'(npop - n0), 64'd10);

    // 2: decode stall fills queue, then releases everything in order
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
    chk("t2_req_low", {63'h0, obs_req},   64'd0);
    chk("t2_valid",   {63'h0, obs_valid}, 64'd1);
    chk("t2_busy",    {63'h0, obs_idle},  64'd0);
    gnt_en = 1'b0;
    n0 = npop;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    chk("t2_held", 64'(npop - n0), 64'd4);
    chk("t2_idle", {63'h0, obs_idle}, 64'd1);
    gnt_en = 1'b1;

    // 3: latency 3, redirect with two fetches in flight
    lat = 3;
    step(1'b0, '0, 1'b1);
    chk("t3_req0", {63'h0, obs_req}, 64'd1);
    step(1'b0, '0, 1'b1);
    chk("t3_req1", {63'h0, obs_req}, 64'd1);
    step(1'b1, 64'h8000_1000, 1'b1);
    chk("t3_req_redir", {63'h0, obs_req}, 64'd0);
    chk("t3_inflight",  64'(q_addr.size()), 64'd2);
    n0 = npop;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    chk("t3_any_pop", {63'h0, npop > n0}, 64'd1);
    drain();

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 64'h8000_2000, 1'b1);
    chk("t4_rsp_pop", {62'h0, obs_rsp, obs_pop}, 64'd3);
    step(1'b0, '0, 1'b1);
    chk("t4_empty", {63'h0, obs_valid}, 64'd0);
    chk("t4_req",   {63'h0, obs_req},   64'd1);
    chk("t4_addr",  obs_addr, 64'h8000_2000);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // 5: wrap at the top of the address space; low bits of target ignored
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("t5_addr_top", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, '0, 1'b1);
    chk("t5_addr_wrap", obs_addr, 64'h0);
    n0 = npop;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    chk("t5_pops", 64'(npop - n0), 64'd6);
    drain();

    // 6: asynchronous reset with two fetches in flight
    lat = 3;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
    chk("t6_pre_valid",    {63'h0, obs_valid}, 64'd1);
    chk("t6_pre_inflight", 64'(q_addr.size()), 64'd2);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_valid = 1'b0;
    q_addr.delete();
    q_due.delete();
    #1;
    chk("t6_req",   {63'h0, imem_req},   64'd0);
    chk("t6_valid", {63'h0, inst_valid}, 64'd0);
    chk("t6_inst",  {32'h0, inst},       64'd0);
    chk("t6_idle",  {63'h0, idle},       64'd1);
    lat = 1;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    release_rst();
    step(1'b0, '0, 1'b1);
    chk("t6_restart_req",  {63'h0, obs_req}, 64'd1);
    chk("t6_restart_addr", obs_addr, 64'h8000_0000);
    n0 = npop;
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    chk("t6_pops", 64'(npop - n0), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
